// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load followed by a dependent instruction inserts one bubble and freezes
// PC and IF/ID for that cycle. A flush squashes the decode slot and takes
// priority over a hazard.
module id_ex_hazard_reg #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 11,
    parameter int MEMREAD_BIT = 9,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        if_id_rs,
    input  logic [4:0]        if_id_rt,
    input  logic [4:0]        if_id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic [4:0]        id_ex_rs,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [DATA_W-1:0] id_ex_a,
    output logic [DATA_W-1:0] id_ex_b,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [DATA_W-1:0] id_ex_pc4,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   hazard;
    logic   load_bubble;
    logic   cnt_inc;

    // Hazard detection, next-state and freeze controls
    always_comb begin
        state_next  = RUN;
        load_bubble = 1'b0;
        cnt_inc     = 1'b0;
        hazard      = (state == RUN)
                   && id_ex_ctrl[MEMREAD_BIT]
                   && (id_ex_rt != 5'd0)
                   && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        if (flush) begin
            load_bubble = 1'b1;
        end else if (hazard) begin
            load_bubble = 1'b1;
            cnt_inc     = 1'b1;
            state_next  = BUBBLE;
        end
        pc_write    = reset & (~hazard | flush);
        if_id_write = reset & (~hazard | flush);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // ID/EX register: bubble on flush/hazard, otherwise load decode outputs
    always_ff @(posedge clk) begin
        if (!reset || load_bubble) begin
            id_ex_rs   <= '0;
            id_ex_rt   <= '0;
            id_ex_rd   <= '0;
            id_ex_ctrl <= '0;
            id_ex_a    <= '0;
            id_ex_b    <= '0;
            id_ex_imm  <= '0;
            id_ex_pc4  <= '0;
        end else begin
            id_ex_rs   <= if_id_rs;
            id_ex_rt   <= if_id_rt;
            id_ex_rd   <= if_id_rd;
            id_ex_ctrl <= id_ctrl;
            id_ex_a    <= id_rdata1;
            id_ex_b    <= id_rdata2;
            id_ex_imm  <= id_imm;
            id_ex_pc4  <= id_pc4;
        end
    end

    // Saturating count of inserted load-use bubbles
    always_ff @(posedge clk) begin
        if (!reset)
            stall_count <= '0;
        else if (cnt_inc && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed scenarios followed by random traffic,
// all outputs checked every cycle against a behavioural model.
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 11;
    localparam int MRB    = 9;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [4:0]        if_id_rs, if_id_rt, if_id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic              flush;
    logic [4:0]        id_ex_rs, id_ex_rt, id_ex_rd;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [DATA_W-1:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc4;
    logic              pc_write, if_id_write;
    logic [CNT_W-1:0]  stall_count;

    id_ex_hazard_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .MEMREAD_BIT(MRB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b),
        .id_ex_imm(id_ex_imm), .id_ex_pc4(id_ex_pc4),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_count(stall_count)
    );

    // Model of what EX should hold: a record of the instruction last accepted
    typedef struct {
        int rs, rt, rd, ctrl;
        logic [DATA_W-1:0] a, b, imm, pc4;
    } instr_t;

    instr_t m_ex;
    int     m_cnt;
    bit     m_prev_bubble;   // previous edge inserted a load-use bubble
    bit     last_pw;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit model_hazard();
        if (m_prev_bubble) return 1'b0;
        if (((m_ex.ctrl >> MRB) & 1) == 0) return 1'b0;
        if (m_ex.rt == 0) return 1'b0;
        return (m_ex.rt == int'(if_id_rs)) || (m_ex.rt == int'(if_id_rt));
    endfunction

    function automatic instr_t nop();
        instr_t n;
        n.rs = 0; n.rt = 0; n.rd = 0; n.ctrl = 0;
        n.a = '0; n.b = '0; n.imm = '0; n.pc4 = '0;
        return n;
    endfunction

    task automatic set_id(input int rs, input int rt, input int rd, input int ctrl);
        if_id_rs  = 5'(rs);
        if_id_rt  = 5'(rt);
        if_id_rd  = 5'(rd);
        id_ctrl   = CTRL_W'(ctrl);
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
        id_imm    = $urandom;
        id_pc4    = $urandom;
    endtask

    // One cycle: check freeze outputs before the edge, advance model, check EX regs after
    task automatic step();
        bit hz;
        bit exp_pw;
        #2;
        hz     = model_hazard();
        exp_pw = reset && (!hz || flush);
        chk("pc_write", 64'(pc_write), 64'(exp_pw));
        chk("if_id_write", 64'(if_id_write), 64'(exp_pw));
        last_pw = exp_pw;
        @(posedge clk);
        if (!reset) begin
            m_ex = nop(); m_cnt = 0; m_prev_bubble = 0;
        end else if (flush) begin
            m_ex = nop(); m_prev_bubble = 0;
        end else if (hz) begin
            m_ex = nop(); m_prev_bubble = 1;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_ex.rs = int'(if_id_rs); m_ex.rt = int'(if_id_rt); m_ex.rd = int'(if_id_rd);
            m_ex.ctrl = int'(id_ctrl);
            m_ex.a = id_rdata1; m_ex.b = id_rdata2; m_ex.imm = id_imm; m_ex.pc4 = id_pc4;
            m_prev_bubble = 0;
        end
        #1;
        chk("id_ex_rs", 64'(id_ex_rs), 64'(m_ex.rs));
        chk("id_ex_rt", 64'(id_ex_rt), 64'(m_ex.rt));
        chk("id_ex_rd", 64'(id_ex_rd), 64'(m_ex.rd));
        chk("id_ex_ctrl", 64'(id_ex_ctrl), 64'(m_ex.ctrl));
        chk("id_ex_a", 64'(id_ex_a), 64'(m_ex.a));
        chk("id_ex_b", 64'(id_ex_b), 64'(m_ex.b));
        chk("id_ex_imm", 64'(id_ex_imm), 64'(m_ex.imm));
        chk("id_ex_pc4", 64'(id_ex_pc4), 64'(m_ex.pc4));
        chk("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    localparam int LD  = (1 << MRB) | 3;
    localparam int ALU = 12'h0A5 & ~(1 << MRB);

    initial begin
        int sat_exp [5] = '{1, 2, 3, 3, 3};
        m_ex = nop(); m_cnt = 0; m_prev_bubble = 0; last_pw = 0;
        flush = 0;

        // Reset held two cycles with nonzero inputs
        @(posedge clk); #1;
        reset = 0;
        set_id(5, 6, 7, LD);
        step();
        step();
        chk("rst_ctrl", 64'(id_ex_ctrl), 64'd0);
        reset = 1;
        set_id(1, 2, 3, ALU);
        step();

        // Load-use: load writes r5, next instruction reads r5
        set_id(1, 5, 9, LD);
        step();
        set_id(5, 7, 8, ALU);
        step();
        chk("lu_pc_write_frozen", 64'(last_pw), 64'd0);
        chk("lu_bubble_ctrl", 64'(id_ex_ctrl), 64'd0);
        chk("lu_cnt", 64'(stall_count), 64'd1);
        step();
        chk("lu_reload_rs", 64'(id_ex_rs), 64'd5);

        // Load to r0 never stalls
        set_id(0, 0, 4, LD);
        step();
        set_id(0, 3, 2, ALU);
        step();
        chk("rt0_pc_write", 64'(last_pw), 64'd1);
        chk("rt0_cnt", 64'(stall_count), 64'd1);

        // Flush coincident with a hazard
        set_id(2, 6, 1, LD);
        step();
        set_id(6, 1, 1, ALU);
        flush = 1;
        step();
        flush = 0;
        chk("fl_pc_write", 64'(last_pw), 64'd1);
        chk("fl_cnt", 64'(stall_count), 64'd1);

        // Counter saturation
        reset = 0;
        step();
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            set_id(4, 3, 0, LD);
            step();
            set_id(3, 3, 6, ALU);
            step();
            chk("sat_cnt", 64'(stall_count), 64'(sat_exp[i]));
            step();
        end

        // Back-to-back dependent ALU ops never stall
        for (int i = 0; i < 4; i++) begin
            set_id(10 + i, 11 + i, 11 + i, ALU);
            step();
            chk("flow_no_stall", 64'(last_pw), 64'd1);
        end

        // Random traffic; a stalled instruction is re-presented unchanged
        for (int i = 0; i < 400; i++) begin
            if (last_pw) begin
                int c;
                c = int'($urandom_range(0, (1 << CTRL_W) - 1));
                set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), c);
            end
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 39) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
